// File: rtl/oam_dma.sv
// Sprite-memory DMA: a CPU write to 16'h4014 halts the CPU and copies the
// 256-byte page {page,8'h00..8'hFF} into the register at 16'h2004.
module oam_dma (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    output logic        cpu_rdy,
    output logic        bus_sel,
    output logic [15:0] mem_addr,
    output logic        mem_rw,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din
);

    localparam logic [15:0] TRIGGER_ADDR = 16'h4014;
    localparam logic [15:0] DEST_ADDR    = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t     state_q, state_d;
    logic       parity_q, parity_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            index_q  <= 8'h00;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            page_q   <= page_d;
            index_q  <= index_d;
            data_q   <= data_d;
        end
    end

    // HALT on an even cycle inserts ALIGN so every READ lands on parity 0.
    always_comb begin
        state_d  = state_q;
        parity_d = ~parity_q;
        page_d   = page_q;
        index_d  = index_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (!cpu_rw && (cpu_addr == TRIGGER_ADDR)) begin
                    page_d  = cpu_dout;
                    index_d = 8'h00;
                    state_d = HALT;
                end
            end
            HALT:  state_d = parity_q ? READ : ALIGN;
            ALIGN: state_d = READ;
            READ: begin
                data_d  = mem_din;
                state_d = WRITE;
            end
            WRITE: begin
                index_d = index_q + 8'h01;
                state_d = (index_q == 8'hFF) ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so no CPU input reaches them.
    always_comb begin
        cpu_rdy  = 1'b0;
        bus_sel  = 1'b1;
        mem_addr = 16'h0000;
        mem_rw   = 1'b1;
        mem_dout = 8'h00;
        case (state_q)
            IDLE: begin
                cpu_rdy = 1'b1;
                bus_sel = 1'b0;
            end
            READ:  mem_addr = {page_q, index_q};
            WRITE: begin
                mem_addr = DEST_ADDR;
                mem_rw   = 1'b0;
                mem_dout = data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: memory returns addr[7:0]^8'h5A; a bus monitor
// logs every DMA read and write for the checks below.
module tb_oam_dma;

    logic        clk_ph1;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;
    logic        cpu_rdy;
    logic        bus_sel;
    logic [15:0] mem_addr;
    logic        mem_rw;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;

    int compared;
    int mismatched;

    int cyc;
    int busy_cnt;
    int setup_cnt;
    int wr_cnt;
    int rd_cnt;
    int wr_addr_bad;
    int idle_bad;
    logic [7:0]  wr_data [0:2047];
    logic [15:0] rd_addr [0:2047];
    logic        rd_par  [0:2047];

    oam_dma dut (
        .clk_ph1  (clk_ph1),
        .rst      (rst),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_rw   (cpu_rw),
        .cpu_rdy  (cpu_rdy),
        .bus_sel  (bus_sel),
        .mem_addr (mem_addr),
        .mem_rw   (mem_rw),
        .mem_dout (mem_dout),
        .mem_din  (mem_din)
    );

    initial begin
        clk_ph1 = 1'b0;
        forever #5 clk_ph1 = ~clk_ph1;
    end

    always_comb mem_din = mem_addr[7:0] ^ 8'h5A;

    // Cycle number since reset release; its LSB is the expected parity.
    always @(posedge clk_ph1 or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        busy_cnt = 0; setup_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        wr_addr_bad = 0; idle_bad = 0;
    end

    always @(negedge clk_ph1) begin
        if (rst) begin
            if (!cpu_rdy) busy_cnt <= busy_cnt + 1;
            if (bus_sel && !mem_rw) begin
                wr_data[wr_cnt] <= mem_dout;
                if (mem_addr != 16'h2004) wr_addr_bad <= wr_addr_bad + 1;
                wr_cnt <= wr_cnt + 1;
            end
            if (bus_sel && mem_rw && (mem_addr != 16'h0000)) begin
                rd_addr[rd_cnt] <= mem_addr;
                rd_par[rd_cnt]  <= cyc[0];
                rd_cnt <= rd_cnt + 1;
            end
            if (bus_sel && mem_rw && (mem_addr == 16'h0000)) setup_cnt <= setup_cnt + 1;
            if (!bus_sel && ((mem_addr != 16'h0000) || !mem_rw || (mem_dout != 8'h00)))
                idle_bad <= idle_bad + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic rw, input logic [7:0] data);
        cpu_addr = addr;
        cpu_rw   = rw;
        cpu_dout = data;
        @(negedge clk_ph1);
        cpu_addr = 16'h0000;
        cpu_rw   = 1'b1;
        cpu_dout = 8'h00;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_ph1);
    endtask

    task automatic waitParity(input logic p);
        while (cyc[0] != p) @(negedge clk_ph1);
    endtask

    // Triggers a copy of one page from the current cycle and checks the
    // whole transfer against the memory model.
    task automatic runTransfer(input logic [7:0] page, input string tag, input bit retrigger);
        int busy_base, setup_base, wr_base, rd_base, wbad_base;
        int exp_busy, n, derr, aerr;
        busy_base  = busy_cnt;
        setup_base = setup_cnt;
        wr_base    = wr_cnt;
        rd_base    = rd_cnt;
        wbad_base  = wr_addr_bad;
        exp_busy   = (cyc[0] == 0) ? 513 : 514;
        applyStimulus(16'h4014, 1'b0, page);
        if (retrigger) begin
            applyStimulus(16'h4014, 1'b0, 8'h07);
            applyStimulus(16'h4014, 1'b0, 8'h07);
        end
        n = 0;
        while (!cpu_rdy && n < 700) begin
            @(negedge clk_ph1);
            n++;
        end
        checkOutput({tag, "_timeout"}, (n < 700), 1);
        checkOutput({tag, "_busy"}, busy_cnt - busy_base, exp_busy);
        checkOutput({tag, "_setup"}, setup_cnt - setup_base, exp_busy - 512);
        checkOutput({tag, "_writes"}, wr_cnt - wr_base, 256);
        checkOutput({tag, "_reads"}, rd_cnt - rd_base, 256);
        checkOutput({tag, "_waddr"}, wr_addr_bad - wbad_base, 0);
        checkOutput({tag, "_raddr_first"}, rd_addr[rd_base], {page, 8'h00});
        checkOutput({tag, "_raddr_last"}, rd_addr[rd_base + 255], {page, 8'hFF});
        checkOutput({tag, "_rd_parity"}, rd_par[rd_base], 0);
        checkOutput({tag, "_wdata_first"}, wr_data[wr_base], 8'h5A);
        checkOutput({tag, "_wdata_last"}, wr_data[wr_base + 255], 8'hA5);
        derr = 0;
        aerr = 0;
        for (int i = 0; i < 256; i++) begin
            if (wr_data[wr_base + i] !== (i[7:0] ^ 8'h5A)) derr++;
            if (rd_addr[rd_base + i] !== {page, i[7:0]}) aerr++;
        end
        checkOutput({tag, "_wdata_errs"}, derr, 0);
        checkOutput({tag, "_raddr_errs"}, aerr, 0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_cpu_rdy"}, cpu_rdy, 1);
        checkOutput({tag, "_bus_sel"}, bus_sel, 0);
        checkOutput({tag, "_mem_rw"}, mem_rw, 1);
        checkOutput({tag, "_mem_addr"}, mem_addr, 16'h0000);
        checkOutput({tag, "_mem_dout"}, mem_dout, 8'h00);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base, n;
        compared   = 0;
        mismatched = 0;
        rst      = 1'b0;
        cpu_addr = 16'h0000;
        cpu_rw   = 1'b1;
        cpu_dout = 8'h00;
        #1;
        checkIdleOutputs("reset");
        waitCycles(3);
        rst = 1'b1;
        waitCycles(2);

        $display("[TB] odd alignment, page 02 with ignored retriggers");
        waitParity(1'b0);
        runTransfer(8'h02, "odd", 1'b1);

        $display("[TB] even alignment, page 02");
        waitCycles(1);
        waitParity(1'b1);
        runTransfer(8'h02, "even", 1'b0);

        $display("[TB] non-trigger bus cycles");
        base = busy_cnt;
        applyStimulus(16'h4014, 1'b1, 8'h02);
        waitCycles(3);
        checkOutput("nt_read_busy", busy_cnt - base, 0);
        applyStimulus(16'h4015, 1'b0, 8'h02);
        waitCycles(3);
        checkOutput("nt_4015_busy", busy_cnt - base, 0);
        applyStimulus(16'h4013, 1'b0, 8'h02);
        waitCycles(3);
        checkOutput("nt_4013_busy", busy_cnt - base, 0);
        checkOutput("nt_cpu_rdy", cpu_rdy, 1);

        $display("[TB] reset after the 100th write");
        base = wr_cnt;
        applyStimulus(16'h4014, 1'b0, 8'h01);
        n = 0;
        while ((wr_cnt - base) < 100 && n < 400) begin
            @(posedge clk_ph1);
            n++;
        end
        checkOutput("mid_reach_100", wr_cnt - base, 100);
        #2 rst = 1'b0;
        #1;
        checkIdleOutputs("mid_reset");
        waitCycles(4);
        checkOutput("mid_no_more_writes", wr_cnt - base, 100);
        rst = 1'b1;
        runTransfer(8'h03, "restart", 1'b0);

        $display("[TB] back-to-back page FF wrap, then page 05");
        runTransfer(8'hFF, "wrap", 1'b0);
        runTransfer(8'h05, "after_wrap", 1'b0);

        waitCycles(2);
        checkOutput("idle_outputs_clean", idle_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
